// File: rtl/btn_step_ctrl_pkg.sv
// rtl/btn_step_ctrl_pkg.sv - shared state encodings and default filter lengths
package btn_step_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   localparam logic [19:0] DEBOUNCE_DEFAULT  = 20'd1000000;
   localparam logic [19:0] SW_STABLE_DEFAULT = 20'd1000000;

endpackage

// File: rtl/btn_step_ctrl_sync2.sv
// rtl/btn_step_ctrl_sync2.sv - two-flop synchronizer for asynchronous inputs
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/btn_step_ctrl.sv
// rtl/btn_step_ctrl.sv - debounced single-step button and display-select switch filter
module btn_step_ctrl
   import btn_step_ctrl_pkg::*;
#(
   parameter logic [19:0] DEBOUNCE  = DEBOUNCE_DEFAULT,
   parameter logic [19:0] SW_STABLE = SW_STABLE_DEFAULT
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       btn_raw,
   input  logic [1:0] sw_raw,
   output logic       step_pulse,
   output logic       step_level,
   output logic [1:0] swOp,
   output logic [7:0] press_count
);

   logic        btn_s;
   logic [1:0]  sw_s;
   logic [1:0]  sw_c;
   logic [19:0] cnt;
   logic [19:0] scnt;
   logic        pulse_arm;
   btn_state_t  state;

   sync2 #(.WIDTH(1)) u_sync_btn (.CLK(CLK), .Reset(Reset), .d(btn_raw), .q(btn_s));
   sync2 #(.WIDTH(2)) u_sync_sw  (.CLK(CLK), .Reset(Reset), .d(sw_raw),  .q(sw_s));

   // pulse_arm marks the PRESS_WAIT->PRESSED entry; step_pulse follows it one cycle later
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state       <= IDLE;
         cnt         <= '0;
         pulse_arm   <= 1'b0;
         step_pulse  <= 1'b0;
         step_level  <= 1'b0;
         press_count <= 8'h00;
      end else begin
         pulse_arm  <= 1'b0;
         step_pulse <= pulse_arm;
         if (step_pulse)
            press_count <= press_count + 8'd1;
         case (state)
            IDLE: begin
               if (btn_s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!btn_s) begin
                  state <= IDLE;
               end else if (cnt == DEBOUNCE - 20'd1) begin
                  state      <= PRESSED;
                  step_level <= 1'b1;
                  pulse_arm  <= 1'b1;
               end else begin
                  cnt <= cnt + 20'd1;
               end
            end
            PRESSED: begin
               if (!btn_s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (btn_s) begin
                  state <= PRESSED;
               end else if (cnt == DEBOUNCE - 20'd1) begin
                  state      <= IDLE;
                  step_level <= 1'b0;
               end else begin
                  cnt <= cnt + 20'd1;
               end
            end
         endcase
      end
   end

   // any change restarts the stability window; scnt parks at the terminal value
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         sw_c <= 2'b00;
         scnt <= '0;
         swOp <= 2'b00;
      end else if (sw_s != sw_c) begin
         sw_c <= sw_s;
         scnt <= '0;
      end else if (scnt == SW_STABLE - 20'd1) begin
         swOp <= sw_c;
      end else begin
         scnt <= scnt + 20'd1;
      end
   end

endmodule

// File: tb/tb_btn_step_ctrl.sv
// tb/tb_btn_step_ctrl.sv - scoreboard bench for btn_step_ctrl with short filter lengths
module tb_btn_step_ctrl;

   localparam logic [19:0] DB = 20'd4;
   localparam logic [19:0] SS = 20'd4;
   // first sampling edge +7 posedges, seen at the following negedge
   localparam int PULSE_LAT = 8;

   logic       CLK = 1'b0;
   logic       Reset = 1'b0;
   logic       btn_raw = 1'b0;
   logic [1:0] sw_raw = 2'b00;
   logic       step_pulse;
   logic       step_level;
   logic [1:0] swOp;
   logic [7:0] press_count;

   int cyc = 0;
   int passed = 0;
   int total = 0;
   int pulses_seen = 0;
   int exp_count = 0;
   int pulse_q[$];

   btn_step_ctrl #(.DEBOUNCE(DB), .SW_STABLE(SS)) dut (
      .CLK(CLK), .Reset(Reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
      .step_pulse(step_pulse), .step_level(step_level), .swOp(swOp),
      .press_count(press_count)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int obs, input int exp);
      total++;
      if (obs == exp) passed++;
      else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic start_press();
      btn_raw = 1'b1;
      pulse_q.push_back(cyc + PULSE_LAT);
      exp_count = (exp_count + 1) % 256;
   endtask

   task automatic press(input int hold, input int rel);
      start_press();
      tick(hold);
      btn_raw = 1'b0;
      tick(rel);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_pulse"}, int'(step_pulse), 0);
      check_eq({tag, "_level"}, int'(step_level), 0);
      check_eq({tag, "_swop"}, int'(swOp), 0);
      check_eq({tag, "_count"}, int'(press_count), 0);
   endtask

   task automatic switch_glitch();
      int saw11 = 0;
      for (int k = 0; k < 16; k++) begin
         if (k == 0) sw_raw = 2'b10;
         if (k == 1) sw_raw = 2'b11;
         if (k == 3) sw_raw = 2'b10;
         tick(1);
         if (swOp == 2'b11) saw11 = 1;
         if (k == 8) check_eq("sw_before_accept", int'(swOp), 0);
         if (k == 9) check_eq("sw_accept_edge", int'(swOp), 2);
      end
      check_eq("sw_never_11", saw11, 0);
      check_eq("sw_final", int'(swOp), 2);
   endtask

   // pulse scoreboard: each pulse must land on the cycle queued for it
   always @(negedge CLK) begin
      if (step_pulse) begin
         pulses_seen++;
         if (pulse_q.size() == 0) check_eq("spurious_pulse", cyc, -1);
         else check_eq("pulse_cycle", cyc, pulse_q.pop_front());
      end else if (pulse_q.size() > 0 && cyc > pulse_q[0]) begin
         check_eq("missing_pulse", cyc, pulse_q.pop_front());
      end
   end

   initial begin
      int s;
      int n;
      tick(3);
      check_all_zero("reset");
      Reset = 1'b1;
      tick(2);

      s = pulses_seen;
      for (int i = 0; i < 256; i++) begin
         press(10, 8);
         if (i == 254) check_eq("count_ff", int'(press_count), 255);
      end
      check_eq("wrap_count", int'(press_count), 0);
      check_eq("wrap_pulses", pulses_seen - s, 256);

      n = cyc;
      start_press();
      tick(6);
      check_eq("level_before_accept", int'(step_level), 0);
      tick(1);
      check_eq("level_at_accept", int'(step_level), 1);
      tick(13);
      n = cyc;
      btn_raw = 1'b0;
      tick(6);
      check_eq("level_release_hold", int'(step_level), 1);
      tick(1);
      check_eq("level_release_drop", int'(step_level), 0);
      tick(3);
      check_eq("clean_count", int'(press_count), exp_count);

      for (int k = 0; k < 4; k++) begin
         btn_raw = (k % 2 == 0);
         tick(1);
      end
      press(12, 10);
      check_eq("bounce_count", int'(press_count), exp_count);

      start_press();
      tick(12);
      btn_raw = 1'b0;
      tick(2);
      btn_raw = 1'b1;
      tick(1);
      btn_raw = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick(1);
         check_eq($sformatf("rel_bounce_level_%0d", k), int'(step_level), (k < 7) ? 1 : 0);
      end
      tick(3);
      check_eq("rel_bounce_count", int'(press_count), exp_count);

      fork
         switch_glitch();
         press(12, 10);
      join
      check_eq("concurrent_count", int'(press_count), exp_count);

      btn_raw = 1'b1;
      tick(4);
      Reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         check_all_zero($sformatf("midreset%0d", k));
      end
      exp_count = 0;
      Reset = 1'b1;
      pulse_q.push_back(cyc + PULSE_LAT);
      exp_count = 1;
      tick(12);
      btn_raw = 1'b0;
      tick(10);
      check_eq("after_reset_count", int'(press_count), 1);

      tick(20);
      check_eq("queue_drained", pulse_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

endmodule
